line_window_ctrl: RTL and testbench
===================================

# line_window_ctrl

Schedules a bank of N_LINES `line_buf` instances to form a vertical pixel window for kernel stages (e.g. 3x3 filters). Steers the incoming video stream line by line into the buffers round-robin, pops all buffers together once N_LINES lines are held, and joins their read streams into one AXI4-Stream whose beat carries one pixel column, oldest line in lane 0. After each window line it flushes the oldest buffer so it can accept the next input line.

## Interface
- N_LINES, 3: number of attached line buffers (2..8).
- TDATA_WIDTH, 32: pixel width per lane.
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-low.
- video_i  axi4_stream_if.slave  TDATA_WIDTH  input video; tuser = SOF, tlast = EOL.
- video_o  axi4_stream_if.master  N_LINES*TDATA_WIDTH  window column; lane k = bits [k*TDATA_WIDTH +: TDATA_WIDTH].
- wr_tdata_o / wr_tlast_o / wr_tuser_o  out  TDATA_WIDTH / 1 / 1  shared write data to all buffers.
- wr_tvalid_o  out  N_LINES  per-buffer write valid (one-hot on wr_sel).
- wr_tready_i  in  N_LINES  per-buffer write ready.
- buf_unread_i  in  N_LINES  per-buffer unread_o.
- buf_pop_o  out  N_LINES  per-buffer pop_line_i.
- buf_flush_o  out  N_LINES  per-buffer flush_line_i.
- rd_tdata_i  in  N_LINES*TDATA_WIDTH  buffer read data, packed by index.
- rd_tvalid_i / rd_tlast_i  in  N_LINES each  buffer read valid / last.
- rd_tready_o  out  N_LINES  read ready, same value broadcast to all.
- err_o  out  1  one-cycle pulse on lane tlast mismatch.

## Operation
- Write steering: wr_sel (index 0..N_LINES-1). video_i routed combinationally to buffer wr_sel; video_i.tready = wr_tready_i[wr_sel]. wr_sel increments (mod N_LINES) on accepted beat with tlast. Accepted beat with tuser sets wr_sel to 1 if it also carries tlast, else 0, and performs frame restart (below).
- oldest (index): buffer holding the oldest line; lane k of output maps to buffer (oldest + k) mod N_LINES.
- FSM:
  - FILL: wait until buf_unread_i all ones -> POP; set primed.
  - WAIT: (primed) wait until buf_unread_i[last_flushed] = 1 -> POP.
  - POP: buf_pop_o = all ones for exactly one cycle -> STREAM.
  - STREAM: join; on output-register load of a beat with lane-0 tlast -> FLUSH.
  - FLUSH: buf_flush_o[oldest] = 1 for one cycle; last_flushed <= oldest; oldest <= oldest+1 mod N_LINES -> WAIT.
- Join: beat taken when all rd_tvalid_i = 1 and output register free (!video_o.tvalid or video_o.tready); rd_tready_o = all ones exactly in that cycle, else zero.
- Output tlast = lane-0 tlast. If any lane tlast differs from lane 0 on a taken beat: err_o pulses, beat still forwarded.
- Output tuser: sof_pending set on frame restart; first output beat after it carries tuser = 1 and clears it.
- Frame restart (accepted video_i tuser): FSM -> FILL, primed = 0, oldest = 0, last_flushed = 0, output register cleared (tvalid = 0), sof_pending = 1. Restart has priority over every other update in that cycle.

## Timing
- Reset values: video_o.tvalid/tlast/tuser = 0, video_o.tdata = 0, buf_pop_o = 0, buf_flush_o = 0, rd_tready_o = 0, err_o = 0, wr_sel = 0, oldest = 0, FSM = FILL, sof_pending = 1.
- video_i -> buffer path: zero latency (combinational).
- unread condition -> pop: 1 cycle (state register), pop held 1 cycle.
- Join -> video_o: 1 cycle register; full throughput when downstream ready is held high.
- Output tlast beat loaded -> buf_flush_o pulse next cycle; flush never coincides with pop.
- video_o holds tdata/tlast/tuser stable while tvalid && !tready.
- N_LINES not a power of two: all index arithmetic wraps explicitly at N_LINES-1 -> 0.

## Test plan
- Reset then 3 lines of 4 pixels (values 0x10+n) with N_LINES=3 -> one pop pulse to all, 4 output beats, lane0 = line0, lane2 = line2, tuser on beat 0, tlast on beat 3, flush on buffer 0.
- Continue with line 3 -> written to buffer 0; second window lanes = lines 1,2,3 (oldest=1); flush buffer 1.
- Random video_o.tready backpressure 50 % -> output beats identical in value/order to ready-high run; no beat dropped or duplicated.
- SOF mid-STREAM -> video_o.tvalid 0 next cycle, FSM FILL, wr_sel 0; next window requires 3 fresh lines and starts with tuser.
- Buffer 1 forced tlast one beat early -> err_o single-cycle pulse on that beat; lane-0 tlast governs end of line.
- Reset asserted during STREAM -> all outputs at reset values asynchronously; after release full FILL sequence resumes correctly.

Source files
------------

// File: rtl/line_window_ctrl_if.sv
// AXI4-Stream bundle used on the video input and window output.
// tuser marks start of frame, tlast marks end of line.
interface axi4_stream_if #(
    parameter int DW = 32
);
    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          tready;
    logic          tlast;
    logic          tuser;

    modport master (
        output tdata, tvalid, tlast, tuser,
        input  tready
    );

    modport slave (
        input  tdata, tvalid, tlast, tuser,
        output tready
    );
endinterface

// File: rtl/line_window_ctrl.sv
// Steers video lines round-robin into a bank of line buffers and joins
// their replayed lines into one column-wide window stream.
module line_window_ctrl #(
    parameter int N_LINES     = 3,
    parameter int TDATA_WIDTH = 32
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    axi4_stream_if.slave                   video_i,
    axi4_stream_if.master                  video_o,
    output logic [TDATA_WIDTH-1:0]         wr_tdata_o,
    output logic                           wr_tlast_o,
    output logic                           wr_tuser_o,
    output logic [N_LINES-1:0]             wr_tvalid_o,
    input  logic [N_LINES-1:0]             wr_tready_i,
    input  logic [N_LINES-1:0]             buf_unread_i,
    output logic [N_LINES-1:0]             buf_pop_o,
    output logic [N_LINES-1:0]             buf_flush_o,
    input  logic [N_LINES*TDATA_WIDTH-1:0] rd_tdata_i,
    input  logic [N_LINES-1:0]             rd_tvalid_i,
    input  logic [N_LINES-1:0]             rd_tlast_i,
    output logic [N_LINES-1:0]             rd_tready_o,
    output logic                           err_o
);
    localparam int W  = TDATA_WIDTH;
    localparam int IW = $clog2(N_LINES);

    typedef logic [IW-1:0] idx_t;
    localparam idx_t LAST = idx_t'(N_LINES - 1);

    typedef enum logic [2:0] {
        S_FILL,
        S_WAIT,
        S_POP,
        S_STREAM,
        S_FLUSH
    } state_t;

    state_t state;
    idx_t   wr_sel;
    idx_t   oldest;
    idx_t   last_flushed;
    logic   primed;
    logic   sof_pending;

    logic   in_acc;
    logic   restart;
    logic   take;
    logic   mismatch;
    int     lane_src;

    logic [N_LINES*W-1:0] lane_data;
    logic [N_LINES-1:0]   lane_last;

    // Index arithmetic wraps explicitly so non power-of-two banks work.
    function automatic idx_t wrap_inc(idx_t i);
        return (i == LAST) ? '0 : i + idx_t'(1);
    endfunction

    function automatic logic [N_LINES-1:0] onehot(idx_t i);
        logic [N_LINES-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    assign wr_tdata_o     = video_i.tdata;
    assign wr_tlast_o     = video_i.tlast;
    assign wr_tuser_o     = video_i.tuser;
    assign video_i.tready = wr_tready_i[wr_sel];

    always_comb begin
        wr_tvalid_o         = '0;
        wr_tvalid_o[wr_sel] = video_i.tvalid;
    end

    assign in_acc  = video_i.tvalid & video_i.tready;
    assign restart = in_acc & video_i.tuser;

    // Lane k reads buffer (oldest + k) so lane 0 is always the oldest line.
    always_comb begin
        lane_data = '0;
        lane_last = '0;
        lane_src  = 0;
        for (int k = 0; k < N_LINES; k++) begin
            lane_src = int'(oldest) + k;
            if (lane_src >= N_LINES) begin
                lane_src = lane_src - N_LINES;
            end
            lane_data[k*W +: W] = rd_tdata_i[lane_src*W +: W];
            lane_last[k]        = rd_tlast_i[lane_src];
        end
    end

    assign mismatch = |(lane_last ^ {N_LINES{lane_last[0]}});

    assign take = (state == S_STREAM) && (&rd_tvalid_i) &&
                  (!video_o.tvalid || video_o.tready);

    assign rd_tready_o = {N_LINES{take}};

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state          <= S_FILL;
            wr_sel         <= '0;
            oldest         <= '0;
            last_flushed   <= '0;
            primed         <= 1'b0;
            sof_pending    <= 1'b1;
            video_o.tvalid <= 1'b0;
            video_o.tdata  <= '0;
            video_o.tlast  <= 1'b0;
            video_o.tuser  <= 1'b0;
            buf_pop_o      <= '0;
            buf_flush_o    <= '0;
            err_o          <= 1'b0;
        end else begin
            buf_pop_o   <= '0;
            buf_flush_o <= '0;
            err_o       <= 1'b0;

            if (video_o.tready) begin
                video_o.tvalid <= 1'b0;
            end

            if (in_acc && video_i.tlast) begin
                wr_sel <= wrap_inc(wr_sel);
            end

            unique case (state)
                S_FILL: begin
                    if (&buf_unread_i) begin
                        state     <= S_POP;
                        primed    <= 1'b1;
                        buf_pop_o <= '1;
                    end
                end
                S_WAIT: begin
                    if (primed && buf_unread_i[last_flushed]) begin
                        state     <= S_POP;
                        buf_pop_o <= '1;
                    end
                end
                S_POP: begin
                    state <= S_STREAM;
                end
                S_STREAM: begin
                    if (take) begin
                        video_o.tvalid <= 1'b1;
                        video_o.tdata  <= lane_data;
                        video_o.tlast  <= lane_last[0];
                        video_o.tuser  <= sof_pending;
                        sof_pending    <= 1'b0;
                        err_o          <= mismatch;
                        if (lane_last[0]) begin
                            state       <= S_FLUSH;
                            buf_flush_o <= onehot(oldest);
                        end
                    end
                end
                S_FLUSH: begin
                    last_flushed <= oldest;
                    oldest       <= wrap_inc(oldest);
                    state        <= S_WAIT;
                end
                default: begin
                    state <= S_FILL;
                end
            endcase

            // A new frame overrides whatever else happened this cycle.
            if (restart) begin
                state          <= S_FILL;
                primed         <= 1'b0;
                oldest         <= '0;
                last_flushed   <= '0;
                sof_pending    <= 1'b1;
                video_o.tvalid <= 1'b0;
                video_o.tlast  <= 1'b0;
                video_o.tuser  <= 1'b0;
                buf_pop_o      <= '0;
                buf_flush_o    <= '0;
                err_o          <= 1'b0;
                wr_sel         <= video_i.tlast ? idx_t'(1) : '0;
            end
        end
    end
endmodule

// File: tb/tb_line_window_ctrl.sv
// Bench for line_window_ctrl: behavioural line buffers around the DUT
// and a window scoreboard built directly from the frame contents.
module tb_line_window_ctrl;
    localparam int N    = 3;
    localparam int W    = 32;
    localparam int MAXW = 16;

    logic clk_i = 1'b0;
    logic rst_i;
    always #5 clk_i = ~clk_i;

    axi4_stream_if #(.DW(W))   vin  ();
    axi4_stream_if #(.DW(N*W)) vout ();

    logic [W-1:0]   wr_tdata;
    logic           wr_tlast;
    logic           wr_tuser;
    logic [N-1:0]   wr_tvalid;
    logic [N-1:0]   wr_tready;
    logic [N-1:0]   buf_unread;
    logic [N-1:0]   buf_pop;
    logic [N-1:0]   buf_flush;
    logic [N*W-1:0] rd_tdata;
    logic [N-1:0]   rd_tvalid;
    logic [N-1:0]   rd_tlast;
    logic [N-1:0]   rd_tready;
    logic           err;

    line_window_ctrl #(.N_LINES(N), .TDATA_WIDTH(W)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .video_i      (vin),
        .video_o      (vout),
        .wr_tdata_o   (wr_tdata),
        .wr_tlast_o   (wr_tlast),
        .wr_tuser_o   (wr_tuser),
        .wr_tvalid_o  (wr_tvalid),
        .wr_tready_i  (wr_tready),
        .buf_unread_i (buf_unread),
        .buf_pop_o    (buf_pop),
        .buf_flush_o  (buf_flush),
        .rd_tdata_i   (rd_tdata),
        .rd_tvalid_i  (rd_tvalid),
        .rd_tlast_i   (rd_tlast),
        .rd_tready_o  (rd_tready),
        .err_o        (err)
    );

    // Line buffer model: holds one line, replays it on pop, empties on flush.
    logic [W-1:0] mem [N][MAXW];
    int           blen [N];
    int           rptr [N];
    logic         complete [N];
    logic         unread [N];
    logic         reading [N];
    logic         force_early [N];

    always_comb begin
        rd_tdata   = '0;
        rd_tvalid  = '0;
        rd_tlast   = '0;
        wr_tready  = '0;
        buf_unread = '0;
        for (int k = 0; k < N; k++) begin
            wr_tready[k]        = !complete[k] || wr_tuser;
            buf_unread[k]       = unread[k];
            rd_tvalid[k]        = reading[k];
            rd_tdata[k*W +: W]  = mem[k][rptr[k]];
            rd_tlast[k]         = reading[k] && (force_early[k] ?
                                  (rptr[k] >= blen[k] - 2) :
                                  (rptr[k] == blen[k] - 1));
        end
    end

    always @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int k = 0; k < N; k++) begin
                blen[k] <= 0; rptr[k] <= 0;
                complete[k] <= 1'b0; unread[k] <= 1'b0; reading[k] <= 1'b0;
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                if (buf_flush[k]) begin
                    blen[k] <= 0; rptr[k] <= 0;
                    complete[k] <= 1'b0; unread[k] <= 1'b0; reading[k] <= 1'b0;
                end else begin
                    if (buf_pop[k]) begin
                        reading[k] <= 1'b1; rptr[k] <= 0; unread[k] <= 1'b0;
                    end else if (reading[k] && rd_tready[k]) begin
                        if (rptr[k] == blen[k] - 1) reading[k] <= 1'b0;
                        else rptr[k] <= rptr[k] + 1;
                    end
                    if (wr_tvalid[k] && wr_tready[k] && blen[k] < MAXW) begin
                        mem[k][blen[k]] <= wr_tdata;
                        blen[k] <= blen[k] + 1;
                        if (wr_tlast) begin
                            complete[k] <= 1'b1; unread[k] <= 1'b1;
                        end
                    end
                end
            end
            if (|(wr_tvalid & wr_tready) && wr_tuser) begin
                for (int k = 0; k < N; k++) begin
                    blen[k] <= 0; rptr[k] <= 0;
                    complete[k] <= 1'b0; unread[k] <= 1'b0; reading[k] <= 1'b0;
                    if (wr_tvalid[k]) begin
                        mem[k][0] <= wr_tdata;
                        blen[k] <= 1;
                        complete[k] <= wr_tlast; unread[k] <= wr_tlast;
                    end
                end
            end
        end
    end

    typedef struct packed {
        logic [N*W-1:0] d;
        logic           l;
        logic           u;
    } beat_t;

    beat_t        expq [$];
    logic [W-1:0] fr [8][MAXW];
    int           flog [$];

    int checks   = 0;
    int errors   = 0;
    int consumed = 0;
    int pop_cnt  = 0;
    int err_cnt  = 0;
    int err_beat = -1;
    bit rnd_en   = 1'b0;

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void gen_frame(int m, int w, bit ramp);
        for (int i = 0; i < m; i++)
            for (int j = 0; j < w; j++)
                fr[i][j] = ramp ? W'(32'h10 + i*w + j) : W'($urandom());
    endfunction

    // Window win holds lines win..win+N-1, oldest in lane 0.
    function automatic void push_frame(int m, int w);
        beat_t b;
        for (int win = 0; win + N <= m; win++)
            for (int j = 0; j < w; j++) begin
                for (int k = 0; k < N; k++) b.d[k*W +: W] = fr[win+k][j];
                b.l = (j == w - 1);
                b.u = (win == 0 && j == 0);
                expq.push_back(b);
            end
    endfunction

    task automatic send_beat(input logic [W-1:0] d, input logic l,
                             input logic u);
        int n = 0;
        vin.tdata = d; vin.tlast = l; vin.tuser = u; vin.tvalid = 1'b1;
        @(negedge clk_i);
        while (!vin.tready && n < 4000) begin
            n++;
            @(negedge clk_i);
        end
        chk("input_accept", vin.tready, 1'b1);
        @(posedge clk_i);
        #1;
        vin.tvalid = 1'b0; vin.tuser = 1'b0;
    endtask

    task automatic send_lines(int l0, int l1, int w, bit skip_first);
        for (int i = l0; i <= l1; i++)
            for (int j = 0; j < w; j++)
                if (!(skip_first && i == 0 && j == 0))
                    send_beat(fr[i][j], j == w - 1, i == 0 && j == 0);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (expq.size() != 0 && n < 5000) begin
            @(negedge clk_i);
            n++;
        end
        chk(tag, expq.size(), 0);
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_stream(input string tag);
        int n = 0;
        while (!vout.tvalid && n < 500) begin
            @(negedge clk_i);
            n++;
        end
        chk(tag, vout.tvalid, 1'b1);
    endtask

    always @(posedge clk_i) begin
        #1;
        vout.tready = rnd_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    logic  stall_prev = 1'b0;
    logic  err_prev   = 1'b0;
    logic  pop_prev   = 1'b0;
    beat_t saved;
    beat_t cur;
    beat_t expb;

    always @(negedge clk_i) begin
        if (!rst_i) begin
            stall_prev = 1'b0; err_prev = 1'b0; pop_prev = 1'b0;
        end else begin
            cur = {vout.tdata, vout.tlast, vout.tuser};
            if (stall_prev && vout.tvalid) chk("hold_stable", cur, saved);
            if (err) begin
                err_cnt++;
                err_beat = consumed;
                chk("err_single_cycle", err_prev, 1'b0);
            end
            if (buf_pop != '0) begin
                pop_cnt++;
                chk("pop_all", buf_pop, 3'b111);
                chk("pop_not_flush", buf_flush, 3'b000);
                chk("pop_single_cycle", pop_prev, 1'b0);
            end
            if (buf_flush != '0) begin
                chk("flush_onehot", $onehot(buf_flush), 1'b1);
                for (int k = 0; k < N; k++) if (buf_flush[k]) flog.push_back(k);
            end
            if (vout.tvalid && vout.tready) begin
                chk("beat_expected", expq.size() != 0, 1'b1);
                if (expq.size() != 0) begin
                    expb = expq.pop_front();
                    chk("beat", cur, expb);
                end
                consumed++;
            end
            stall_prev = vout.tvalid && !vout.tready;
            saved      = cur;
            err_prev   = err;
            pop_prev   = |buf_pop;
        end
    end

    initial begin
        int pc0;
        int e0;
        int eb;
        for (int k = 0; k < N; k++) force_early[k] = 1'b0;
        vin.tvalid = 1'b0; vin.tdata = '0; vin.tlast = 1'b0; vin.tuser = 1'b0;
        vout.tready = 1'b1;
        rst_i = 1'b1;
        #1 rst_i = 1'b0;
        #11;
        chk("rst_tvalid", vout.tvalid, 1'b0);
        chk("rst_tlast_tuser", {vout.tlast, vout.tuser}, 2'b00);
        chk("rst_tdata", vout.tdata, '0);
        chk("rst_pop_flush", {buf_pop, buf_flush}, 6'b0);
        chk("rst_rd_tready", rd_tready, 3'b000);
        chk("rst_err", err, 1'b0);
        @(posedge clk_i);
        #1 rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        chk("idle_no_pop", buf_pop, 3'b000);

        // Ramp frame, ready held high: four windows, flush order 0,1,2,0.
        gen_frame(6, 4, 1'b1);
        push_frame(6, 4);
        send_lines(0, 5, 4, 1'b0);
        drain("drain_ramp");
        repeat (3) @(posedge clk_i);
        #1;
        chk("ramp_pop_count", pop_cnt, 4);
        chk("ramp_flush_count", flog.size(), 4);
        chk("ramp_flush_order", {flog[3][1:0], flog[2][1:0], flog[1][1:0],
            flog[0][1:0]}, 8'b00_10_01_00);

        // Random data under 50 % output backpressure.
        rnd_en = 1'b1;
        gen_frame(6, $urandom_range(2, 12), 1'b0);
        begin
            int w;
            w = $urandom_range(2, 12);
            gen_frame(6, w, 1'b0);
            push_frame(6, w);
            send_lines(0, 5, w, 1'b0);
        end
        drain("drain_backpressure");
        rnd_en = 1'b0;
        @(posedge clk_i);
        #1;

        // New frame arriving while a window is streaming.
        gen_frame(3, 8, 1'b0);
        push_frame(3, 8);
        send_lines(0, 2, 8, 1'b0);
        wait_stream("sof_stream_started");
        @(posedge clk_i);
        #1;
        gen_frame(3, 5, 1'b0);
        send_beat(fr[0][0], 1'b0, 1'b1);
        chk("sof_tvalid_cleared", vout.tvalid, 1'b0);
        expq.delete();
        push_frame(3, 5);
        pc0 = pop_cnt;
        vin.tdata = fr[0][1]; vin.tlast = 1'b0; vin.tvalid = 1'b1;
        #1;
        chk("sof_wr_sel_zero", wr_tvalid, 3'b001);
        send_lines(0, 1, 5, 1'b1);
        chk("sof_no_pop_early", pop_cnt, pc0);
        send_lines(2, 2, 5, 1'b0);
        drain("drain_after_sof");
        chk("sof_one_pop", pop_cnt, pc0 + 1);

        // Buffer 1 flags tlast one beat early.
        force_early[1] = 1'b1;
        e0 = err_cnt;
        eb = consumed + 6 - 2;
        gen_frame(3, 6, 1'b0);
        push_frame(3, 6);
        send_lines(0, 2, 6, 1'b0);
        drain("drain_err_frame");
        chk("err_pulse_count", err_cnt - e0, 1);
        chk("err_pulse_beat", err_beat, eb);
        force_early[1] = 1'b0;

        // Reset in the middle of a streaming window.
        rnd_en = 1'b1;
        gen_frame(3, 8, 1'b0);
        push_frame(3, 8);
        send_lines(0, 2, 8, 1'b0);
        wait_stream("rst_stream_started");
        #2 rst_i = 1'b0;
        #1;
        chk("arst_tvalid", vout.tvalid, 1'b0);
        chk("arst_tdata", vout.tdata, '0);
        chk("arst_flags", {vout.tlast, vout.tuser, err}, 3'b000);
        chk("arst_pop_flush", {buf_pop, buf_flush, rd_tready}, 9'b0);
        expq.delete();
        @(posedge clk_i);
        @(posedge clk_i);
        #3 rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        gen_frame(4, 7, 1'b0);
        push_frame(4, 7);
        send_lines(0, 3, 7, 1'b0);
        drain("drain_after_reset");
        rnd_en = 1'b0;
        chk("err_total", err_cnt, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
